pwm_sample_sequencer: RTL and testbench

Schedules audio/control samples into the PWM_MarkI duty input (Dato) on exact PWM frame boundaries. Accepts signed samples from upstream (filter or sample source) over a valid/ready handshake and buffers them in a small FIFO. Converts each sample to offset-binary duty and presents it to the PWM for exactly one frame of PERIOD clocks. Handles priming, underrun and enable/flush sequencing.

---
 rtl/pwm_seq_pkg.sv | 24 ++
 rtl/pwm_sample_sequencer_if.sv | 11 +
 rtl/pwm_seq_fifo.sv | 58 +++++
 rtl/pwm_sample_sequencer.sv | 126 ++++++++++++
 tb/tb_pwm_sample_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM sample sequencer: state encoding,
// midscale constant and signed-to-offset-binary conversion.
package pwm_seq_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDERRUN} state_t;

    // Helpers work on a wide word; callers truncate to their own DATA_W.
    localparam int unsigned MAX_W = 64;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] midscale(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

    // Flipping the sign bit maps two's complement onto offset binary.
    function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] s,
                                                   input int unsigned w);
        return s ^ midscale(w);
    endfunction

endpackage

// File: rtl/pwm_sample_sequencer_if.sv
// Upstream sample stream (valid/ready) feeding the PWM sample sequencer.
interface pwm_sample_sequencer_if #(
    parameter int unsigned DATA_W = 22
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pwm_seq_fifo.sv
// Small synchronous FIFO with flush and occupancy level; flush beats push/pop.
module pwm_seq_fifo
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = cnt_w(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pwm_sample_sequencer.sv
// Feeds buffered samples to the PWM duty input, one per PERIOD-clock frame.
// Optional UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module pwm_sample_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 22,
    parameter int unsigned PERIOD     = 22,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRIME_LVL  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          clr_underrun,
    pwm_sample_sequencer_if.slave         in_if,
    output logic [DATA_W-1:0]             Dato,
    output logic                          load,
    output logic [cnt_w(PERIOD)-1:0]      contador,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_count
`endif
);
    localparam int unsigned CNT_W = cnt_w(PERIOD);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale(DATA_W));
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(PERIOD - 1);

    state_t            state;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_duty;
    logic              full;
    logic              empty;
    logic              running;
    logic              boundary;
    logic              pop;
    logic              starve;

    assign running   = (state == RUN) || (state == UNDERRUN);
    assign boundary  = running && (contador == LAST);
    assign pop       = enable && (((state == PRIME) && (fifo_level >= LVL_W'(PRIME_LVL)))
                                  || (boundary && !empty));
    assign starve    = enable && boundary && empty;
    assign head_duty = DATA_W'(to_offset(MAX_W'(head), DATA_W));
    assign in_if.in_ready = !full;

    pwm_seq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_if.in_valid),
        .pop   (pop),
        .flush (flush),
        .wdata (in_if.in_data),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            Dato     <= MIDSCALE;
            load     <= 1'b0;
            contador <= '0;
            underrun <= 1'b0;
        end else begin
            load <= 1'b0;
            // A fresh underrun event takes priority over a clear request.
            if (starve)            underrun <= 1'b1;
            else if (clr_underrun) underrun <= 1'b0;

            if (!enable) begin
                state    <= IDLE;
                Dato     <= MIDSCALE;
                contador <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state    <= PRIME;
                        contador <= '0;
                    end
                    PRIME: begin
                        contador <= '0;
                        if (pop) begin
                            Dato  <= head_duty;
                            load  <= 1'b1;
                            state <= RUN;
                        end
                    end
                    RUN, UNDERRUN: begin
                        contador <= boundary ? '0 : contador + CNT_W'(1);
                        if (pop) begin
                            Dato  <= head_duty;
                            load  <= 1'b1;
                            state <= RUN;
                        end else if (boundary) begin
                            Dato  <= MIDSCALE;
                            state <= UNDERRUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (starve) begin
            if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
        end else if (clr_underrun) begin
            underrun_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Scoreboard bench for pwm_sample_sequencer: accepted samples queue their expected
// duty word; a negedge monitor pops and compares on every load pulse.
module tb_pwm_sample_sequencer;
    localparam int unsigned DATA_W     = 22;
    localparam int unsigned PERIOD     = 22;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PRIME_LVL  = 2;
    localparam int unsigned CNT_W      = $clog2(PERIOD);
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] MID  = 22'h200000;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              flush;
    logic              clr_underrun;
    logic [DATA_W-1:0] Dato;
    logic              load;
    logic [CNT_W-1:0]  contador;
    logic [LVL_W-1:0]  fifo_level;
    logic              underrun;
`ifdef UNDERRUN_CNT_EN
    logic [15:0]       underrun_count;
`endif

    pwm_sample_sequencer_if #(.DATA_W(DATA_W)) sif ();

    pwm_sample_sequencer #(
        .DATA_W     (DATA_W),
        .PERIOD     (PERIOD),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PRIME_LVL  (PRIME_LVL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .clr_underrun   (clr_underrun),
        .in_if          (sif),
        .Dato           (Dato),
        .load           (load),
        .contador       (contador),
        .fifo_level     (fifo_level),
        .underrun       (underrun)
`ifdef UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    // Reference conversion: offset binary is the signed value plus half range.
    function automatic logic [DATA_W-1:0] model_duty(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = s + MID;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        sif.in_data  = d;
        sif.in_valid = 1'b1;
        while (!sif.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!sif.in_ready) begin
            timeout("push_ready");
        end else begin
            tick();
            exp_q.push_back(model_duty(d));
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_cnt(input logic [CNT_W-1:0] v, input string name);
        int n;
        n = 0;
        while (contador != v && n < 4 * PERIOD) begin
            tick();
            n++;
        end
        if (contador != v) timeout(name);
    endtask

    task automatic drain(input int bound, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) timeout(name);
    endtask

    task automatic pulse_clr();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
    endtask

    // Monitor: every load must deliver the next queued duty word, loads in an
    // uninterrupted run are whole frames apart, and Dato never moves silently
    // except back to midscale.
    logic [DATA_W-1:0] prev_dato;
    logic              track_ok;
    int                cyc_since;
    always @(negedge clk) begin
        if (reset) begin
            prev_dato = MID;
            track_ok  = 1'b0;
            cyc_since = 0;
        end else begin
            cyc_since++;
            if (load) begin
                if (exp_q.size() == 0) begin
                    timeout("load_without_sample");
                end else begin
                    check("dato_on_load", Dato, exp_q.pop_front());
                end
                if (track_ok) check("frame_len_mod", cyc_since % PERIOD, 0);
                track_ok  = 1'b1;
                cyc_since = 0;
            end else if (Dato != prev_dato) begin
                check("dato_silent_change", Dato, MID);
            end
            if (!enable) track_ok = 1'b0;
            prev_dato = Dato;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LVL_W-1:0] lvl;
        int               n;
        int               sz;

        reset = 1'b1; enable = 1'b0; flush = 1'b0; clr_underrun = 1'b0;
        sif.in_valid = 1'b0; sif.in_data = '0;
        repeat (3) tick();
        check("rst_dato", Dato, MID);
        check("rst_load", load, 0);
        check("rst_contador", contador, 0);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", sif.in_ready, 1);
        tick();

        // Enabled with an empty FIFO: parked in PRIME.
        enable = 1'b1;
        repeat (30) tick();
        check("prime_dato", Dato, MID);
        check("prime_contador", contador, 0);
        check("prime_load", load, 0);

        // Extremes of the conversion, then starvation.
        push(22'h000000);
        push(22'h1FFFFF);
        push(22'h200000);
        drain(120, "drain_basic");
        repeat (PERIOD + 2) tick();
        check("starve_underrun", underrun, 1);
        check("starve_dato", Dato, MID);
        push(22'h000001);
        drain(60, "drain_recover");
        check("underrun_sticky", underrun, 1);
        pulse_clr();
        check("underrun_clr", underrun, 0);

        // Random stream with random gaps; underruns in between are legal.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 35)) tick();
            push(DATA_W'($urandom));
        end
        drain(2000, "drain_random");
        pulse_clr();

        // Fill while idle, then check back-pressure.
        enable = 1'b0;
        tick();
        check("idle_dato", Dato, MID);
        check("idle_contador", contador, 0);
        check("idle_level", fifo_level, 0);
        for (int i = 0; i < FIFO_DEPTH; i++) push(DATA_W'($urandom));
        check("full_level", fifo_level, FIFO_DEPTH);
        check("full_in_ready", sif.in_ready, 0);
        sif.in_data  = DATA_W'($urandom);
        sif.in_valid = 1'b1;
        repeat (3) tick();
        sif.in_valid = 1'b0;
        check("full_ignore", fifo_level, FIFO_DEPTH);

        enable = 1'b1;
        n = 0;
        while (exp_q.size() == FIFO_DEPTH && n < 6) begin
            tick();
            n++;
        end
        check("prime_pop_level", fifo_level, FIFO_DEPTH - 1);

        // Push lands on the same edge as the boundary pop.
        wait_cnt(CNT_W'(PERIOD - 1), "wait_boundary");
        sif.in_data  = DATA_W'($urandom);
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        exp_q.push_back(model_duty(sif.in_data));
        check("push_pop_level", fifo_level, FIFO_DEPTH - 1);

        // Drop enable mid-frame, then re-enable.
        wait_cnt(CNT_W'(10), "wait_cnt10");
        lvl = fifo_level;
        enable = 1'b0;
        tick();
        check("disable_dato", Dato, MID);
        check("disable_contador", contador, 0);
        check("disable_level", fifo_level, lvl);
        repeat (3) tick();
        sz = exp_q.size();
        enable = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (exp_q.size() == sz && n < 10);
        check("reenable_latency", n, 3);

        // Flush with a coincident push; the next boundary must starve.
        wait_cnt(CNT_W'(5), "wait_cnt5");
        flush        = 1'b1;
        sif.in_data  = DATA_W'($urandom);
        sif.in_valid = 1'b1;
        tick();
        flush        = 1'b0;
        sif.in_valid = 1'b0;
        exp_q.delete();
        check("flush_level", fifo_level, 0);
        n = 0;
        while (!underrun && n < PERIOD + 2) begin
            tick();
            n++;
        end
        check("flush_underrun", underrun, 1);
        check("flush_dato", Dato, MID);
        pulse_clr();
        check("clr_again", underrun, 0);
        wait_cnt(CNT_W'(PERIOD - 1), "wait_set_wins");
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("set_wins", underrun, 1);

        // Asynchronous reset mid-frame with three samples buffered.
        wait_cnt(CNT_W'(1), "wait_cnt1");
        for (int i = 0; i < 3; i++) push(DATA_W'($urandom));
        wait_cnt(CNT_W'(15), "wait_cnt15");
        check("pre_reset_level", fifo_level, 3);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("arst_dato", Dato, MID);
        check("arst_load", load, 0);
        check("arst_contador", contador, 0);
        check("arst_level", fifo_level, 0);
        check("arst_underrun", underrun, 0);
        tick();
        reset = 1'b0;
        tick();
        check("arst_in_ready", sif.in_ready, 1);

        // Two samples then starve for three boundaries.
        push(DATA_W'($urandom));
        push(DATA_W'($urandom));
        n = 0;
        while (exp_q.size() != 1 && n < 10) begin
            tick();
            n++;
        end
        if (exp_q.size() != 1) timeout("wait_first_load");
        repeat (4 * PERIOD) tick();
        check("final_underrun", underrun, 1);
        check("final_dato", Dato, MID);
        check("final_queue_empty", exp_q.size(), 0);
`ifdef UNDERRUN_CNT_EN
        check("underrun_count", underrun_count, 3);
        pulse_clr();
        check("underrun_count_clr", underrun_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
